// File: rtl/riscv32_cpu.sv
// riscv32_cpu: single-cycle RV32I core with a 1024-word instruction ROM (rom_image) and 1024-word data RAM.
// Optional macro RISCV32_FLAGS_EN drives zero/negative/overflow status; without it those outputs read 0.
module riscv32_cpu #(
    parameter logic [31:0] reset_pc = 32'h00010000,
    parameter logic [31:0] rom_image [0:1023] = '{default: 32'h00000013}
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instruction_addr,
    output logic [31:0] instruction_read,
    output logic [31:0] data_addr,
    output logic [31:0] data_read,
    output logic [31:0] data_write,
    output logic [3:0]  data_write_byte,
    output logic        data_read_valid,
    output logic        data_write_valid,
    output logic        zero_flag,
    output logic        negative_flag,
    output logic        overflow_flag
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic [31:0]        pc;
    logic [31:0]        next_pc;
    logic               instruction_ready;
    logic [31:0]        fetch_off;
    logic               unused_bits;

    logic [31:0]        instr;
    logic [6:0]         opcode;
    logic [4:0]         rd, rs1, rs2;
    logic [2:0]         funct3;
    logic               funct7_5;
    logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;
    logic               is_op, is_imm, is_branch, is_load, is_store;

    logic [31:0]        rf [0:31];
    logic [31:0]        dmem [0:1023];
    logic signed [31:0] rs1_val, rs2_val, alu_b;
    logic [31:0]        sum, diff;
    logic [31:0]        alu_result;
    logic [31:0]        wb_data;
    logic               rf_we;
    logic               branch_taken;
    logic [3:0]         store_bytes;
    logic [31:0]        store_data;

    // Sub-word load: pick the lane by the low address bits, then extend per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign instruction_addr = pc;
    assign fetch_off        = pc - reset_pc;
    assign unused_bits      = ^fetch_off[1:0];
    assign instruction_read = (fetch_off[31:12] == 20'd0) ? rom_image[fetch_off[11:2]] : NOP_WORD;
    assign instr            = instruction_read;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7_5 = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign is_op     = (opcode == OP_OP);
    assign is_imm    = (opcode == OP_IMM);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
    assign alu_b   = (is_op || is_branch) ? rs2_val : imm_i;
    assign sum     = rs1_val + alu_b;
    assign diff    = rs1_val - alu_b;

    assign data_addr = rs1_val + (is_store ? imm_s : imm_i);
    assign data_read = dmem[data_addr[11:2]];

    always_comb begin
        alu_result   = sum;
        next_pc      = pc + 32'd4;
        rf_we        = 1'b0;
        branch_taken = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_result = imm_u;
                rf_we      = 1'b1;
            end
            OP_AUIPC: begin
                alu_result = pc + imm_u;
                rf_we      = 1'b1;
            end
            OP_JAL: begin
                alu_result = pc + 32'd4;
                next_pc    = pc + imm_j;
                rf_we      = 1'b1;
            end
            OP_JALR: begin
                alu_result = pc + 32'd4;
                next_pc    = sum & ~32'd1;
                rf_we      = 1'b1;
            end
            OP_BRANCH: begin
                alu_result = diff;
                case (funct3)
                    3'b000:  branch_taken = (diff == 32'd0);
                    3'b001:  branch_taken = (diff != 32'd0);
                    3'b100:  branch_taken = (rs1_val < alu_b);
                    3'b101:  branch_taken = !(rs1_val < alu_b);
                    3'b110:  branch_taken = ($unsigned(rs1_val) < $unsigned(alu_b));
                    3'b111:  branch_taken = !($unsigned(rs1_val) < $unsigned(alu_b));
                    default: branch_taken = 1'b0;
                endcase
                if (branch_taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                alu_result = data_addr;
                rf_we      = 1'b1;
            end
            OP_STORE: alu_result = data_addr;
            OP_IMM, OP_OP: begin
                rf_we = 1'b1;
                case (funct3)
                    3'b000:  alu_result = (is_op && funct7_5) ? diff : sum;
                    3'b001:  alu_result = rs1_val << alu_b[4:0];
                    3'b010:  alu_result = {31'd0, rs1_val < alu_b};
                    3'b011:  alu_result = {31'd0, $unsigned(rs1_val) < $unsigned(alu_b)};
                    3'b100:  alu_result = rs1_val ^ alu_b;
                    3'b101:  alu_result = funct7_5 ? $unsigned(rs1_val >>> alu_b[4:0])
                                                   : $unsigned(rs1_val) >> alu_b[4:0];
                    3'b110:  alu_result = rs1_val | alu_b;
                    default: alu_result = rs1_val & alu_b;
                endcase
            end
            default: alu_result = sum;
        endcase
    end

    assign wb_data = is_load ? load_extract(data_read, data_addr[1:0], funct3) : alu_result;

    // Store lanes: SB/SH move the low bits of rs2 up to the addressed lane; misalignment truncates.
    always_comb begin
        store_bytes = 4'b0000;
        store_data  = rs2_val;
        case (funct3[1:0])
            2'b00: begin
                store_bytes = 4'b0001 << data_addr[1:0];
                store_data  = rs2_val << {data_addr[1:0], 3'b000};
            end
            2'b01: begin
                store_bytes = data_addr[1] ? 4'b1100 : 4'b0011;
                store_data  = data_addr[1] ? {rs2_val[15:0], 16'd0} : rs2_val;
            end
            2'b10:   store_bytes = 4'b1111;
            default: store_bytes = 4'b0000;
        endcase
    end

    assign data_read_valid  = instruction_ready && is_load;
    assign data_write_valid = instruction_ready && is_store;
    assign data_write_byte  = data_write_valid ? store_bytes : 4'b0000;
    assign data_write       = store_data;

`ifdef RISCV32_FLAGS_EN
    logic add_ovf, sub_ovf;
    assign add_ovf       = (rs1_val[31] == alu_b[31]) && (sum[31] != rs1_val[31]);
    assign sub_ovf       = (rs1_val[31] != alu_b[31]) && (diff[31] != rs1_val[31]);
    assign zero_flag     = (alu_result == 32'd0);
    assign negative_flag = alu_result[31];
    assign overflow_flag = is_branch ? sub_ovf :
                           ((is_op || is_imm) && funct3 == 3'b000) ?
                           ((is_op && funct7_5) ? sub_ovf : add_ovf) : 1'b0;
`else
    assign zero_flag     = 1'b0;
    assign negative_flag = 1'b0;
    assign overflow_flag = 1'b0;
`endif

    // instruction_ready drops immediately on reset, which also blocks any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc                <= reset_pc;
            instruction_ready <= 1'b0;
        end else begin
            instruction_ready <= 1'b1;
            if (instruction_ready) pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (instruction_ready && rf_we && rd != 5'd0) begin
            rf[rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (data_write_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (data_write_byte[b]) dmem[data_addr[11:2]][8*b +: 8] <= data_write[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv32_cpu.sv
// Bench for riscv32_cpu: runs a small program from the ROM parameter and scores per-PC expectations.
`timescale 1ns/1ps
module tb_riscv32_cpu;

    localparam logic [31:0] RESET_PC = 32'h00010000;
`ifdef RISCV32_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [31:0] PROG [0:1023] = '{
        0:  enc_s(12'd0, 5'd0, 5'd0, 3'b010),                 // SW x0,0(x0)
        1:  enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13),          // ADDI x1,x0,5
        2:  enc_i(12'hFF9, 5'd0, 3'b000, 5'd2, 7'h13),        // ADDI x2,x0,-7
        3:  enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3),            // ADD x3,x1,x2
        4:  enc_s(12'd0, 5'd3, 5'd0, 3'b010),                 // SW x3,0(x0)
        5:  enc_u(20'h7FFFF, 5'd1, 7'h37),                    // LUI x1,0x7FFFF
        6:  enc_i(12'h7FF, 5'd1, 3'b000, 5'd1, 7'h13),        // ADDI x1,x1,0x7FF
        7:  enc_u(20'h80000, 5'd1, 7'h37),                    // LUI x1,0x80000
        8:  enc_i(12'hFFF, 5'd1, 3'b000, 5'd1, 7'h13),        // ADDI x1,x1,-1
        9:  enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'h13),          // ADDI x1,x1,1
        10: enc_s(12'd4, 5'd1, 5'd0, 3'b010),                 // SW x1,4(x0)
        11: enc_u(20'h11223, 5'd1, 7'h37),                    // LUI x1,0x11223
        12: enc_i(12'h380, 5'd1, 3'b000, 5'd1, 7'h13),        // ADDI x1,x1,0x380
        13: enc_s(12'd1, 5'd1, 5'd0, 3'b000),                 // SB x1,1(x0)
        14: enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'h03),          // LB x2,1(x0)
        15: enc_i(12'd1, 5'd0, 3'b100, 5'd3, 7'h03),          // LBU x3,1(x0)
        16: enc_s(12'd8, 5'd2, 5'd0, 3'b010),                 // SW x2,8(x0)
        17: enc_s(12'd12, 5'd3, 5'd0, 3'b010),                // SW x3,12(x0)
        18: enc_s(12'd2, 5'd1, 5'd0, 3'b001),                 // SH x1,2(x0)
        19: enc_i(12'd0, 5'd0, 3'b001, 5'd4, 7'h03),          // LH x4,0(x0)
        20: enc_s(12'd16, 5'd4, 5'd0, 3'b010),                // SW x4,16(x0)
        21: enc_b(13'd8, 5'd0, 5'd0, 3'b000),                 // BEQ x0,x0,+8
        22: enc_i(12'd1, 5'd6, 3'b000, 5'd6, 7'h13),          // ADDI x6,x6,1 (skipped)
        23: enc_b(13'd8, 5'd0, 5'd0, 3'b001),                 // BNE x0,x0,+8
        24: enc_i(12'd2, 5'd6, 3'b000, 5'd6, 7'h13),          // ADDI x6,x6,2
        25: enc_b(13'd8, 5'd3, 5'd2, 3'b100),                 // BLT x2,x3,+8
        26: enc_i(12'd4, 5'd6, 3'b000, 5'd6, 7'h13),          // ADDI x6,x6,4 (skipped)
        27: enc_b(13'd8, 5'd3, 5'd2, 3'b110),                 // BLTU x2,x3,+8
        28: enc_i(12'd8, 5'd6, 3'b000, 5'd6, 7'h13),          // ADDI x6,x6,8
        29: enc_s(12'd20, 5'd6, 5'd0, 3'b010),                // SW x6,20(x0)
        30: 32'h00000000,                                     // all-zero word
        31: 32'h0000000F,                                     // FENCE
        32: enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13),          // ADDI x0,x0,9
        33: enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1),            // ADD x1,x0,x0
        34: enc_s(12'd24, 5'd1, 5'd0, 3'b010),                // SW x1,24(x0)
        35: enc_i(12'h404, 5'd2, 3'b101, 5'd7, 7'h13),        // SRAI x7,x2,4
        36: enc_r(7'd0, 5'd2, 5'd3, 3'b011, 5'd8),            // SLTU x8,x3,x2
        37: enc_s(12'd28, 5'd7, 5'd0, 3'b010),                // SW x7,28(x0)
        38: enc_s(12'd32, 5'd8, 5'd0, 3'b010),                // SW x8,32(x0)
        39: enc_j(21'd8, 5'd9),                               // JAL x9,+8
        40: enc_i(12'd16, 5'd6, 3'b000, 5'd6, 7'h13),         // ADDI x6,x6,16 (skipped)
        41: enc_s(12'd36, 5'd9, 5'd0, 3'b010),                // SW x9,36(x0)
        42: enc_i(12'h101, 5'd0, 3'b000, 5'd5, 7'h67),        // JALR x5,x0,0x101
        default: 32'h00000013
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_addr, instruction_read, data_addr, data_read, data_write;
    logic [3:0]  data_write_byte;
    logic        data_read_valid, data_write_valid;
    logic        zero_flag, negative_flag, overflow_flag;

    riscv32_cpu #(.reset_pc(RESET_PC), .rom_image(PROG)) dut (
        .clk              (clk),
        .reset            (reset),
        .instruction_addr (instruction_addr),
        .instruction_read (instruction_read),
        .data_addr        (data_addr),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_write_byte  (data_write_byte),
        .data_read_valid  (data_read_valid),
        .data_write_valid (data_write_valid),
        .zero_flag        (zero_flag),
        .negative_flag    (negative_flag),
        .overflow_flag    (overflow_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    typedef enum logic [2:0] {K_FLAGS, K_WDATA, K_WBYTE, K_DREAD, K_DADDR, K_NPC, K_IREAD, K_REG5} kind_t;
    typedef struct {
        logic [31:0] pc;
        kind_t       kind;
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    function automatic logic [31:0] pa(input int idx);
        return RESET_PC + 32'(4 * idx);
    endfunction

    function automatic logic [31:0] fl(input logic z, input logic n, input logic o);
        return FLAGS_ON ? {29'd0, z, n, o} : 32'd0;
    endfunction

    task automatic push(input logic [31:0] pc, input kind_t k, input logic [31:0] exp, input string tag);
        sb_t e;
        e.pc = pc; e.kind = k; e.exp = exp; e.tag = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_FLAGS: return {29'd0, zero_flag, negative_flag, overflow_flag};
            K_WDATA: return data_write;
            K_WBYTE: return {28'd0, data_write_byte};
            K_DREAD: return data_read;
            K_DADDR: return data_addr;
            K_IREAD: return instruction_read;
            K_REG5:  return dut.rf[5];
            default: return instruction_addr;
        endcase
    endfunction

    initial begin
        sb_t         e;
        logic        pend;
        logic [31:0] pend_exp;
        string       pend_tag;
        int          cycles;

        push(pa(3),  K_FLAGS, fl(1'b0, 1'b1, 1'b0), "add_flags");
        push(pa(4),  K_WDATA, 32'hFFFFFFFE,          "add_x3");
        push(pa(4),  K_WBYTE, 32'h0000000F,          "sw_lanes");
        push(pa(6),  K_FLAGS, fl(1'b0, 1'b0, 1'b0),  "addi_noovf");
        push(pa(8),  K_FLAGS, fl(1'b0, 1'b0, 1'b1),  "addi_neg_ovf");
        push(pa(9),  K_FLAGS, fl(1'b0, 1'b1, 1'b1),  "addi_pos_ovf");
        push(pa(10), K_WDATA, 32'h80000000,          "ovf_x1");
        push(pa(13), K_WBYTE, 32'h00000002,          "sb_lanes");
        push(pa(13), K_WDATA, 32'h22338000,          "sb_data");
        push(pa(13), K_DADDR, 32'h00000001,          "sb_addr");
        push(pa(14), K_DREAD, 32'hFFFF80FE,          "st_ld_fwd");
        push(pa(16), K_WDATA, 32'hFFFFFF80,          "lb_x2");
        push(pa(17), K_WDATA, 32'h00000080,          "lbu_x3");
        push(pa(18), K_WBYTE, 32'h0000000C,          "sh_lanes");
        push(pa(18), K_WDATA, 32'h33800000,          "sh_data");
        push(pa(19), K_DREAD, 32'h338080FE,          "sh_word");
        push(pa(20), K_WDATA, 32'hFFFF80FE,          "lh_x4");
        push(pa(21), K_NPC,   pa(23),                "beq_taken");
        push(pa(23), K_NPC,   pa(24),                "bne_not_taken");
        push(pa(29), K_WDATA, 32'd10,                "branch_mix");
        push(pa(33), K_FLAGS, fl(1'b1, 1'b0, 1'b0),  "zero_flags");
        push(pa(34), K_WDATA, 32'd0,                 "x0_hardwired");
        push(pa(37), K_WDATA, 32'hFFFFFFF8,          "srai");
        push(pa(38), K_WDATA, 32'd1,                 "sltu");
        push(pa(41), K_WDATA, pa(40),                "jal_link");
        push(pa(42), K_NPC,   32'h00000100,          "jalr_target");
        push(32'h00000100, K_IREAD, 32'h00000013,    "oob_nop");
        push(32'h00000100, K_REG5,  pa(43),          "jalr_link");

        // Held in reset while the first ROM word is a store: nothing may be enabled.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",     instruction_addr, RESET_PC);
        check("rst_wvalid", {31'd0, data_write_valid}, 32'd0);
        check("rst_wbyte",  {28'd0, data_write_byte}, 32'd0);
        check("rst_rvalid", {31'd0, data_read_valid}, 32'd0);
        @(negedge clk) reset = 1'b1;
        #1 check("rel_pc", instruction_addr, RESET_PC);
        @(posedge clk);
        #1 check("ready_pc", instruction_addr, RESET_PC);
        check("ready_wbyte", {28'd0, data_write_byte}, 32'h0000000F);
        @(posedge clk);
        #1 check("retire_pc", instruction_addr, RESET_PC + 32'd4);

        pend = 1'b0;
        pend_exp = '0;
        pend_tag = "";
        cycles = 0;
        while ((sb_q.size() > 0 || pend) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (pend) begin
                check(pend_tag, instruction_addr, pend_exp);
                pend = 1'b0;
            end
            while (sb_q.size() > 0 && sb_q[0].pc == instruction_addr) begin
                e = sb_q.pop_front();
                if (e.kind == K_NPC) begin
                    pend = 1'b1;
                    pend_exp = e.exp;
                    pend_tag = e.tag;
                end else begin
                    check(e.tag, observe(e.kind), e.exp);
                end
            end
        end
        if (sb_q.size() > 0 || pend) check("sb_timeout", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
